// File: rtl/control_sequencer.sv
// Fetch/decode/execute controller for the 8-bit processor: walks the program ROM
// and drives the datapath control bundle, which is registered and live only in EXECUTE.
module control_sequencer (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] instr_addr,
  input  logic [7:0] instr_data,
  output logic [2:0] operation_select,
  output logic       acc_sel,
  output logic [1:0] alu_b_sel,
  output logic [1:0] bank_out_sel,
  output logic [3:0] destination_sel,
  output logic [2:0] source_sel,
  output logic [7:0] bank_data_in,
  output logic       out_valid,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_IMM_FETCH, S_IMM_LATCH, S_EXECUTE, S_HALT
  } state_t;

  localparam logic [2:0] CLS_ALU  = 3'b001;
  localparam logic [2:0] CLS_LDI  = 3'b010;
  localparam logic [2:0] CLS_MOV  = 3'b011;
  localparam logic [2:0] CLS_OUT  = 3'b100;
  localparam logic [2:0] CLS_HALT = 3'b111;

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] imm_q, imm_d;
  logic [2:0] op_q, op_d;
  logic       acc_sel_q, acc_sel_d;
  logic [1:0] b_sel_q, b_sel_d;
  logic [1:0] out_sel_q, out_sel_d;
  logic [3:0] dest_q, dest_d;
  logic [2:0] src_q, src_d;
  logic [7:0] data_q, data_d;
  logic       out_valid_q, out_valid_d;
  logic       halted_q, halted_d;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    imm_d   = imm_q;

    unique case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        ir_d = instr_data;
        pc_d = pc_q + 8'd1;
        case (instr_data[7:5])
          CLS_LDI:  state_d = S_IMM_FETCH;
          CLS_HALT: state_d = S_HALT;
          default:  state_d = S_EXECUTE;
        endcase
      end
      S_IMM_FETCH: state_d = S_IMM_LATCH;
      S_IMM_LATCH: begin
        imm_d   = instr_data;
        pc_d    = pc_q + 8'd1;
        state_d = S_EXECUTE;
      end
      S_EXECUTE: state_d = S_FETCH;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_FETCH;
    endcase

    // Outputs are decoded from the next-state view so the registered bundle lines up with EXECUTE.
    op_d        = '0;
    acc_sel_d   = 1'b0;
    b_sel_d     = '0;
    out_sel_d   = '0;
    dest_d      = '0;
    src_d       = '0;
    data_d      = '0;
    out_valid_d = 1'b0;
    halted_d    = (state_d == S_HALT);

    if (state_d == S_EXECUTE) begin
      case (ir_d[7:5])
        CLS_ALU: begin
          op_d    = ir_d[4:2];
          b_sel_d = ir_d[1:0];
          dest_d  = 4'b0001;
        end
        CLS_LDI: begin
          src_d     = 3'b100;
          acc_sel_d = 1'b1;
          data_d    = imm_d;
          dest_d    = ir_d[3:0];
        end
        CLS_MOV: begin
          src_d     = {1'b0, ir_d[4:3]};
          acc_sel_d = 1'b1;
          dest_d    = 4'b0001 << ir_d[1:0];
        end
        CLS_OUT: begin
          out_sel_d   = ir_d[1:0];
          out_valid_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      pc_q        <= '0;
      ir_q        <= '0;
      imm_q       <= '0;
      op_q        <= '0;
      acc_sel_q   <= 1'b0;
      b_sel_q     <= '0;
      out_sel_q   <= '0;
      dest_q      <= '0;
      src_q       <= '0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      imm_q       <= imm_d;
      op_q        <= op_d;
      acc_sel_q   <= acc_sel_d;
      b_sel_q     <= b_sel_d;
      out_sel_q   <= out_sel_d;
      dest_q      <= dest_d;
      src_q       <= src_d;
      data_q      <= data_d;
      out_valid_q <= out_valid_d;
      halted_q    <= halted_d;
    end
  end

  assign instr_addr       = pc_q;
  assign operation_select = op_q;
  assign acc_sel          = acc_sel_q;
  assign alu_b_sel        = b_sel_q;
  assign bank_out_sel     = out_sel_q;
  assign destination_sel  = dest_q;
  assign source_sel       = src_q;
  assign bank_data_in     = data_q;
  assign out_valid        = out_valid_q;
  assign halted           = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: behavioural ROM, tiny register-bank model,
// and per-cycle checks of the control bundle against hand-computed vectors.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] instr_addr, instr_data;
  logic [2:0] operation_select, source_sel;
  logic       acc_sel, out_valid, halted;
  logic [1:0] alu_b_sel, bank_out_sel;
  logic [3:0] destination_sel;
  logic [7:0] bank_data_in;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] rom [256];
  logic [7:0] regs [4];
  logic [7:0] wval;
  logic [24:0] obs;

  control_sequencer dut (
    .clk(clk), .reset(reset), .instr_addr(instr_addr), .instr_data(instr_data),
    .operation_select(operation_select), .acc_sel(acc_sel), .alu_b_sel(alu_b_sel),
    .bank_out_sel(bank_out_sel), .destination_sel(destination_sel),
    .source_sel(source_sel), .bank_data_in(bank_data_in), .out_valid(out_valid),
    .halted(halted)
  );

  always #5 clk = ~clk;

  // Synchronous program ROM, one-cycle read latency.
  always @(posedge clk) instr_data <= rom[instr_addr];

  // Register bank: ACC is regs[0]; only ALU op 000 (add) is exercised.
  always_comb begin
    wval = 8'h00;
    if (acc_sel)
      wval = (source_sel == 3'b100) ? bank_data_in : regs[source_sel[1:0]];
    else if (operation_select == 3'b000)
      wval = regs[0] + regs[alu_b_sel];
  end

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (reset) regs[k] <= 8'h00;
      else if (destination_sel[k]) regs[k] <= wval;
  end

  assign obs = {operation_select, acc_sel, alu_b_sel, bank_out_sel, destination_sel,
                source_sel, bank_data_in, out_valid, halted};

  function automatic logic [24:0] mk(input logic [2:0] op, input logic acc,
                                     input logic [1:0] b, input logic [1:0] bo,
                                     input logic [3:0] dst, input logic [2:0] src,
                                     input logic [7:0] d, input logic ov, input logic h);
    return {op, acc, b, bo, dst, src, d, ov, h};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge with reset still high; returns at the negedge of the first FETCH.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check({tag, "/ctrl"}, 32'(obs), 32'h0);
    check({tag, "/addr"}, 32'(instr_addr), 32'h0);
    reset = 1'b0;
  endtask

  // Starts at the FETCH negedge, ends at the next instruction's FETCH negedge.
  task automatic run_instr(input string tag, input int cycles, input logic [7:0] addr,
                           input logic [24:0] exp);
    check({tag, "/addr"}, 32'(instr_addr), 32'(addr));
    check({tag, "/fetch"}, 32'(obs), 32'h0);
    for (int i = 1; i < cycles; i++) begin
      @(negedge clk);
      check($sformatf("%s/c%0d", tag, i), 32'(obs), 32'((i == cycles - 1) ? exp : 25'h0));
    end
    @(negedge clk);
  endtask

  task automatic run_halt(input string tag, input logic [7:0] addr);
    check({tag, "/addr"}, 32'(instr_addr), 32'(addr));
    @(negedge clk);
    check({tag, "/decode"}, 32'(obs), 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("%s/hold%0d", tag, i), 32'(obs), 32'(mk(0, 0, 0, 0, 0, 0, 0, 0, 1)));
      check($sformatf("%s/haddr%0d", tag, i), 32'(instr_addr), 32'(addr + 8'd1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    for (int a = 0; a < 256; a++) rom[a] = 8'h00;
    rom[0] = 8'h41; rom[1] = 8'hAA;   // LDI ACC, AA
    rom[2] = 8'h42; rom[3] = 8'h55;   // LDI R1, 55
    rom[4] = 8'h21;                   // ALU add ACC, R1
    rom[5] = 8'h6A;                   // MOV R1 -> R2
    rom[6] = 8'h82;                   // OUT R2
    rom[7] = 8'h40; rom[8] = 8'h33;   // LDI with no destination
    rom[9] = 8'hA0;                   // class 101 -> NOP
    rom[10] = 8'hC0;                  // class 110 -> NOP
    rom[11] = 8'hE0;                  // HALT

    @(negedge clk);
    do_reset("rst0");
    run_instr("ldi_acc", 5, 8'd0, mk(0, 1, 0, 0, 4'b0001, 3'b100, 8'hAA, 0, 0));
    run_instr("ldi_r1",  5, 8'd2, mk(0, 1, 0, 0, 4'b0010, 3'b100, 8'h55, 0, 0));
    run_instr("alu_add", 3, 8'd4, mk(3'b000, 0, 2'b01, 0, 4'b0001, 0, 0, 0, 0));
    check("acc_sum", 32'(regs[0]), 32'hFF);
    run_instr("mov",     3, 8'd5, mk(0, 1, 0, 0, 4'b0100, 3'b001, 0, 0, 0));
    check("r2_mov", 32'(regs[2]), 32'h55);
    run_instr("out",     3, 8'd6, mk(0, 0, 0, 2'b10, 0, 0, 0, 1, 0));
    run_instr("ldi_nodst", 5, 8'd7, mk(0, 1, 0, 0, 4'b0000, 3'b100, 8'h33, 0, 0));
    run_instr("nop101",  3, 8'd9, 25'h0);
    run_instr("nop110",  3, 8'd10, 25'h0);
    run_halt("halt1", 8'd11);
    check("acc_keep", 32'(regs[0]), 32'hFF);

    // Reset out of HALT, then abort an LDI in IMM_LATCH.
    reset = 1'b1;
    do_reset("rst_halt");
    repeat (3) @(negedge clk);
    check("abort/addr", 32'(instr_addr), 32'h1);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("abort/dst%0d", i), 32'(destination_sel), 32'h0);
    end
    check("abort/pc0", 32'(instr_addr), 32'h0);
    reset = 1'b0;
    run_instr("ldi_restart", 5, 8'd0, mk(0, 1, 0, 0, 4'b0001, 3'b100, 8'hAA, 0, 0));

    // PC wrap: LDI at FF takes its immediate from 00, then HALT at 01.
    for (int a = 0; a < 256; a++) rom[a] = 8'h00;
    rom[0] = 8'h5C; rom[1] = 8'hE0; rom[255] = 8'h48;
    reset = 1'b1;
    do_reset("rst_wrap");
    run_instr("ldi_first", 5, 8'd0, mk(0, 1, 0, 0, 4'b1100, 3'b100, 8'hE0, 0, 0));
    for (int a = 2; a < 255; a++) run_instr($sformatf("nop%0d", a), 3, 8'(a), 25'h0);
    run_instr("ldi_wrap", 5, 8'hFF, mk(0, 1, 0, 0, 4'b1000, 3'b100, 8'h5C, 0, 0));
    check("r3_wrap", 32'(regs[3]), 32'h5C);
    check("r2_first", 32'(regs[2]), 32'hE0);
    run_halt("halt_wrap", 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
